dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter that shares the core's single data-memory port between the pipeline Memory stage (core port) and an auxiliary bus master (aux port: UART loader, debug or DMA). The core has priority. The arbiter raises `mem_hold` to stall the pipeline whenever the aux port owns the memory. An optional starvation guard forces aux bursts so the aux port cannot be locked out by a load/store-heavy program. The block sits between the core's `mem_*` signals and the data BRAM, which is synchronous-read with 1-cycle latency.

## Interface
Parameters:
- `AUX_MAX_WAIT`, default 16: cycles aux may wait while core is busy before a forced grant (guard only).
- `AUX_BURST`, default 4: maximum consecutive forced aux grants (guard only).

Ports:
- `clk` in 1: clock.
- `Rst` in 1: reset, synchronous, active-high.
- `core_en` in 4: core byte enables.
- `core_wea` in 1: core write request.
- `core_rea` in 1: core read request.
- `core_addr` in 32: core address.
- `core_din` in 32: core write data.
- `core_dout` out 32: core read data, held until the next core read returns.
- `mem_hold` out 1: stall to pipeline. Asserted when a core request is present but not granted.
- `aux_req` in 1: aux request. Address and data must stay stable until `aux_gnt`.
- `aux_we` in 1: aux write (1) or read (0).
- `aux_be` in 4: aux byte enables.
- `aux_addr` in 32: aux address.
- `aux_wdata` in 32: aux write data.
- `aux_gnt` out 1: aux access issued to memory this cycle.
- `aux_rvalid` out 1: one-cycle pulse; `aux_rdata` is valid.
- `aux_rdata` out 32: aux read data, registered.
- `m_en` out 4, `m_wea` out 1, `m_rea` out 1, `m_addr` out 32, `m_din` out 32: memory request lines.
- `m_dout` in 32: memory read data, valid 1 cycle after `m_rea`.

## Operation
- Core request: `creq = core_rea | core_wea`.
- Each cycle, the grant is combinational from `creq`, `aux_req` and FSM state. Only the granted requester's fields drive `m_*`. With no grant, all `m_*` are 0.
- FSM states:
  - `S_CORE` (reset state): core wins whenever `creq`. Aux is granted only when `!creq`.
  - `S_FORCE` (guard only): aux wins whenever `aux_req`. Core gets `mem_hold=1`.
- FSM transitions:
  - `S_CORE` to `S_FORCE` when `wait_cnt == AUX_MAX_WAIT-1` and `aux_req` and `creq`.
  - `S_FORCE` to `S_CORE` when `burst_cnt == AUX_BURST-1` on a grant, or when `!aux_req`.
- Counters:
  - `wait_cnt` increments each cycle `aux_req & !aux_gnt` and saturates at `AUX_MAX_WAIT-1`. It clears on any aux grant.
  - `burst_cnt` counts grants in `S_FORCE` and clears on entry to `S_FORCE`.
  - Widths are `$clog2(param)`, minimum 1.
- Read-return tracker `rd_owner` ∈ {NONE, CORE, AUX} is registered from the grant of a read.
  - Next cycle, CORE loads `core_dout <= m_dout`.
  - Next cycle, AUX loads `aux_rdata <= m_dout` and pulses `aux_rvalid`.
- Writes produce no return. An aux write completes on its `aux_gnt` cycle.
- `mem_hold = creq & !core_granted`. The core holds its request stable while held.
- Simultaneous `creq` and `aux_req`:
  - In `S_CORE`: core granted, aux waits.
  - In `S_FORCE`: aux granted, core held.
- Back-to-back grants to different owners are legal every cycle; the 1-cycle latency keeps the returns ordered.
- `Rst` mid-operation:
  - Clears FSM, counters and `rd_owner`.
  - Drops a pending `aux_rvalid`.
  - Zeroes `core_dout` and `aux_rdata`.
  - Forces no grant during the reset cycle.

## Timing
- Reset values:
  - `mem_hold`, `aux_gnt`, `aux_rvalid`: 0.
  - `aux_rdata`, `core_dout`: 0.
  - All `m_*`: 0.
  - State `S_CORE`, counters 0.
- Core grant: `m_*` in the same cycle as the request. Read data appears on `core_dout` the following cycle.
- Aux grant: `aux_gnt` in the issue cycle. For reads, `aux_rvalid` and `aux_rdata` follow 1 cycle later.
- `mem_hold` and `aux_gnt` are combinational, with no registered delay.
- Worst aux latency with the guard: `AUX_MAX_WAIT` cycles to grant. Worst added core stall: `AUX_BURST` cycles.

## Configuration
- `DMEM_ARB_STARVE_GUARD_EN` defined: `S_FORCE`, `wait_cnt` and `burst_cnt` are compiled in, as described above.
- Not defined: the FSM is fixed in `S_CORE` and the counters are removed. The core has strict priority, and aux is granted only in cycles with `!creq`. In this build `mem_hold` is asserted only during the reset cycle, and then only if `creq` is present.

## Test plan
- Core read with aux idle: `core_rea=1`, `core_addr=0x40`, memory holds `0xDEADBEEF`. Expect `m_rea=1`, `mem_hold=0`, and `core_dout=0xDEADBEEF` next cycle.
- Simultaneous requests: core write `0x10`/`0x11223344` and aux read `0x20`. Expect the core write first and `aux_gnt` 1 cycle later. `aux_rdata` matches memory[0x20] 2 cycles after the start.
- Starvation (guard on, `AUX_MAX_WAIT=16`, `AUX_BURST=4`): `creq` held high, aux requesting 6 reads. Expect `aux_gnt` first on cycle 16, then 4 consecutive grants with `mem_hold=1`, then the core resumes.
- Guard off: same stimulus. Expect `aux_gnt` never asserted while `creq=1`, and `mem_hold` stays 0.
- Reset mid-read: aux read granted at cycle N, `Rst=1` at N+1. Expect `aux_rvalid=0`, `aux_rdata=0`, and state `S_CORE` at N+2.
- Byte write: aux write with `aux_be=4'b0010`, `aux_wdata=0x0000AB00`. Expect `m_en=4'b0010` and only byte 1 updated.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// dmem_arbiter_if : core, aux-master and data-memory signals of dmem_arbiter.
// Rev 1.0
// ============================================================================
interface dmem_arbiter_if;
  // core (pipeline Memory stage) side
  logic [3:0]  core_en;
  logic        core_wea;
  logic        core_rea;
  logic [31:0] core_addr;
  logic [31:0] core_din;
  logic [31:0] core_dout;
  logic        mem_hold;
  // auxiliary bus master side
  logic        aux_req;
  logic        aux_we;
  logic [3:0]  aux_be;
  logic [31:0] aux_addr;
  logic [31:0] aux_wdata;
  logic        aux_gnt;
  logic        aux_rvalid;
  logic [31:0] aux_rdata;
  // data BRAM side
  logic [3:0]  m_en;
  logic        m_wea;
  logic        m_rea;
  logic [31:0] m_addr;
  logic [31:0] m_din;
  logic [31:0] m_dout;

  // arbiter view
  modport slave (
    input  core_en, core_wea, core_rea, core_addr, core_din,
    output core_dout, mem_hold,
    input  aux_req, aux_we, aux_be, aux_addr, aux_wdata,
    output aux_gnt, aux_rvalid, aux_rdata,
    output m_en, m_wea, m_rea, m_addr, m_din,
    input  m_dout
  );

  // environment view: core, aux master and memory together
  modport master (
    output core_en, core_wea, core_rea, core_addr, core_din,
    input  core_dout, mem_hold,
    output aux_req, aux_we, aux_be, aux_addr, aux_wdata,
    input  aux_gnt, aux_rvalid, aux_rdata,
    input  m_en, m_wea, m_rea, m_addr, m_din,
    output m_dout
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : core-priority arbiter for the shared data-memory port.
// Optional aux starvation guard via `DMEM_ARB_STARVE_GUARD_EN.   Rev 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int AUX_MAX_WAIT = 16,
  parameter int AUX_BURST    = 4
) (
  input  logic          clk,
  input  logic          Rst,
  dmem_arbiter_if.slave arb
);

  localparam logic [1:0] RD_NONE = 2'd0;
  localparam logic [1:0] RD_CORE = 2'd1;
  localparam logic [1:0] RD_AUX  = 2'd2;

  logic        creq;
  logic        force_mode;
  logic        core_gnt;
  logic        aux_gnt;
  logic [1:0]  rd_owner_q, rd_owner_d;
  logic [31:0] core_dout_q, core_dout_d;
  logic [31:0] aux_rdata_q, aux_rdata_d;

  assign creq = arb.core_rea | arb.core_wea;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int WAIT_W  = (AUX_MAX_WAIT > 1) ? $clog2(AUX_MAX_WAIT) : 1;
  localparam int BURST_W = (AUX_BURST > 1) ? $clog2(AUX_BURST) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(AUX_MAX_WAIT - 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(AUX_BURST - 1);

  localparam logic [0:0] S_CORE  = 1'b0;
  localparam logic [0:0] S_FORCE = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q <= S_CORE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CORE: begin
        if (wait_cnt_q == WAIT_LAST && arb.aux_req && creq) begin
          state_d = S_FORCE;
        end
      end
      S_FORCE: begin
        if (!arb.aux_req || (aux_gnt && burst_cnt_q == BURST_LAST)) begin
          state_d = S_CORE;
        end
      end
      default: state_d = S_CORE;
    endcase
  end

  // wait_cnt saturates; burst_cnt restarts on every entry into the forced burst
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (aux_gnt) begin
      wait_cnt_d = '0;
    end else if (arb.aux_req && wait_cnt_q != WAIT_LAST) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    burst_cnt_d = burst_cnt_q;
    if (state_q == S_CORE && state_d == S_FORCE) begin
      burst_cnt_d = '0;
    end else if (state_q == S_FORCE && aux_gnt) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign force_mode = (state_q == S_FORCE);
`else
  // Strict core priority; the parameters only shape the guard build.
  if (AUX_MAX_WAIT >= 1 && AUX_BURST >= 1) begin : g_strict_prio
    assign force_mode = 1'b0;
  end
`endif

  always_comb begin
    core_gnt = 1'b0;
    aux_gnt  = 1'b0;
    if (!Rst) begin
      if (force_mode && arb.aux_req) begin
        aux_gnt = 1'b1;
      end else if (creq) begin
        core_gnt = 1'b1;
      end else if (arb.aux_req) begin
        aux_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    arb.m_en   = '0;
    arb.m_wea  = 1'b0;
    arb.m_rea  = 1'b0;
    arb.m_addr = '0;
    arb.m_din  = '0;
    if (core_gnt) begin
      arb.m_en   = arb.core_en;
      arb.m_wea  = arb.core_wea;
      arb.m_rea  = arb.core_rea;
      arb.m_addr = arb.core_addr;
      arb.m_din  = arb.core_din;
    end else if (aux_gnt) begin
      arb.m_en   = arb.aux_be;
      arb.m_wea  = arb.aux_we;
      arb.m_rea  = !arb.aux_we;
      arb.m_addr = arb.aux_addr;
      arb.m_din  = arb.aux_wdata;
    end
  end

  always_comb begin
    rd_owner_d = RD_NONE;
    if (core_gnt && arb.core_rea) begin
      rd_owner_d = RD_CORE;
    end else if (aux_gnt && !arb.aux_we) begin
      rd_owner_d = RD_AUX;
    end
  end

  // The BRAM output register supplies the data in the return cycle; the
  // local registers keep the last value until the next return of that owner.
  assign core_dout_d = (rd_owner_q == RD_CORE) ? arb.m_dout : core_dout_q;
  assign aux_rdata_d = (rd_owner_q == RD_AUX)  ? arb.m_dout : aux_rdata_q;

  always_ff @(posedge clk) begin
    if (Rst) begin
      rd_owner_q  <= RD_NONE;
      core_dout_q <= '0;
      aux_rdata_q <= '0;
    end else begin
      rd_owner_q  <= rd_owner_d;
      core_dout_q <= core_dout_d;
      aux_rdata_q <= aux_rdata_d;
    end
  end

  assign arb.core_dout  = Rst ? 32'd0 : core_dout_d;
  assign arb.aux_rdata  = Rst ? 32'd0 : aux_rdata_d;
  assign arb.aux_rvalid = !Rst && (rd_owner_q == RD_AUX);
  assign arb.aux_gnt    = aux_gnt;
  assign arb.mem_hold   = creq & !core_gnt;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter : directed + random stimulus against a behavioural model.
// Rev 1.0
// ============================================================================
module tb_dmem_arbiter;
  localparam int AUX_MAX_WAIT = 16;
  localparam int AUX_BURST    = 4;

  logic clk = 1'b0;
  logic Rst;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .AUX_MAX_WAIT(AUX_MAX_WAIT),
    .AUX_BURST   (AUX_BURST)
  ) dut (
    .clk(clk),
    .Rst(Rst),
    .arb(bus)
  );

  always #5 clk = ~clk;

  // synchronous-read data BRAM, 256 words
  logic [31:0] bram [256];
  always @(posedge clk) begin
    if (bus.m_wea) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.m_en[b]) bram[bus.m_addr[9:2]][8*b +: 8] <= bus.m_din[8*b +: 8];
      end
    end
    if (bus.m_rea) bus.m_dout <= bram[bus.m_addr[9:2]];
  end

  // ---------------- reference model state ----------------
  logic [31:0] gmem [256];
  int          pend;          // 0 none, 1 core read returning, 2 aux read returning
  logic [31:0] pend_data;
  logic [31:0] hold_core, hold_aux;
  bit          forced;
  int          waited, burst;
  bit          last_cg, last_ag, obs_ag;
  int          checks = 0;
  int          failures = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle();
    bit creq, cg, ag;
    logic [71:0] em;
    creq = bus.core_rea | bus.core_wea;
    if (Rst) begin
      cg = 0; ag = 0;
    end else if (forced && bus.aux_req) begin
      cg = 0; ag = 1;
    end else begin
      cg = creq; ag = bus.aux_req && !creq;
    end
    if (cg)      em = {2'b0, bus.core_en, bus.core_wea, bus.core_rea, bus.core_addr, bus.core_din};
    else if (ag) em = {2'b0, bus.aux_be, bus.aux_we, !bus.aux_we, bus.aux_addr, bus.aux_wdata};
    else         em = '0;
    chk("mem_hold",   72'(bus.mem_hold), 72'(creq && !cg));
    chk("aux_gnt",    72'(bus.aux_gnt), 72'(ag));
    chk("m_bus",      {2'b0, bus.m_en, bus.m_wea, bus.m_rea, bus.m_addr, bus.m_din}, em);
    chk("aux_rvalid", 72'(bus.aux_rvalid), 72'(!Rst && pend == 2));
    chk("aux_rdata",  72'(bus.aux_rdata), 72'(Rst ? 32'd0 : (pend == 2 ? pend_data : hold_aux)));
    chk("core_dout",  72'(bus.core_dout), 72'(Rst ? 32'd0 : (pend == 1 ? pend_data : hold_core)));
    last_cg = cg;
    last_ag = ag;
    obs_ag  = bus.aux_gnt;
  endtask

  task automatic update_model(input bit cg, input bit ag);
    bit creq;
    int idx;
    creq = bus.core_rea | bus.core_wea;
    if (Rst) begin
      pend = 0; hold_core = '0; hold_aux = '0;
      forced = 0; waited = 0; burst = 0;
      return;
    end
    if (pend == 1) hold_core = pend_data;
    if (pend == 2) hold_aux = pend_data;
    pend = 0;
    if (cg) begin
      idx = int'(bus.core_addr[9:2]);
      if (bus.core_rea) begin pend = 1; pend_data = gmem[idx]; end
      if (bus.core_wea) gmem[idx] = merge(gmem[idx], bus.core_din, bus.core_en);
    end
    if (ag) begin
      idx = int'(bus.aux_addr[9:2]);
      if (!bus.aux_we) begin pend = 2; pend_data = gmem[idx]; end
      else gmem[idx] = merge(gmem[idx], bus.aux_wdata, bus.aux_be);
    end
`ifdef DMEM_ARB_STARVE_GUARD_EN
    // aux is forced after waiting out its budget; the burst ends after
    // AUX_BURST forced grants or when aux stops asking
    if (forced) begin
      if (ag) burst++;
      if (!bus.aux_req || burst == AUX_BURST) forced = 0;
    end else if (bus.aux_req && creq && waited == AUX_MAX_WAIT - 1) begin
      forced = 1;
      burst  = 0;
    end
    if (ag) waited = 0;
    else if (bus.aux_req && waited < AUX_MAX_WAIT - 1) waited++;
`endif
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    update_model(last_cg, last_ag);
    #1;
  endtask

  task automatic core_op(input bit rea, input bit wea, input logic [3:0] en,
                         input logic [31:0] addr, input logic [31:0] din);
    bus.core_rea = rea; bus.core_wea = wea; bus.core_en = en;
    bus.core_addr = addr; bus.core_din = din;
  endtask

  task automatic aux_op(input bit req, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
    bus.aux_req = req; bus.aux_we = we; bus.aux_be = be;
    bus.aux_addr = addr; bus.aux_wdata = wdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_gnt, nreads, cyc;
    bit creq_prev;
    pend = 0; pend_data = '0; hold_core = '0; hold_aux = '0;
    forced = 0; waited = 0; burst = 0;

    // reset, including a core request present during reset
    Rst = 1'b1;
    core_op(0, 0, 4'h0, 32'h0, 32'h0);
    aux_op(0, 0, 4'h0, 32'h0, 32'h0);
    tick();
    core_op(1, 0, 4'hF, 32'h0000_0040, 32'h0);
    aux_op(1, 0, 4'hF, 32'h0000_0020, 32'h0);
    tick();
    Rst = 1'b0;
    core_op(0, 0, 4'h0, 32'h0, 32'h0);
    aux_op(0, 0, 4'h0, 32'h0, 32'h0);
    tick();

    // fill memory through the core port
    for (int i = 0; i < 256; i++) begin
      core_op(0, 1, 4'hF, 32'(i * 4), $urandom());
      tick();
    end

    // core read with aux idle
    core_op(0, 1, 4'hF, 32'h0000_0040, 32'hDEAD_BEEF);
    tick();
    core_op(1, 0, 4'hF, 32'h0000_0040, 32'h0);
    tick();
    core_op(0, 0, 4'h0, 32'h0, 32'h0);
    chk("core_read_deadbeef", 72'(bus.core_dout), 72'(32'hDEAD_BEEF));
    tick();

    // simultaneous core write and aux read
    core_op(0, 1, 4'hF, 32'h0000_0010, 32'h1122_3344);
    aux_op(1, 0, 4'hF, 32'h0000_0020, 32'h0);
    tick();
    core_op(0, 0, 4'h0, 32'h0, 32'h0);
    tick();
    aux_op(0, 0, 4'h0, 32'h0, 32'h0);
    chk("simul_aux_rvalid", 72'(bus.aux_rvalid), 72'(1'b1));
    chk("simul_aux_rdata", 72'(bus.aux_rdata), 72'(gmem[8]));
    tick();

    // starvation: core busy for 40 cycles, aux wants 6 reads
    first_gnt = -1;
    nreads = 0;
    core_op(1, 0, 4'hF, 32'h0000_0100, 32'h0);
    aux_op(1, 0, 4'hF, 32'h0000_0200, 32'h0);
    cyc = 0;
    while (nreads < 6 && cyc < 120) begin
      if (cyc == 40) core_op(0, 0, 4'h0, 32'h0, 32'h0);
      tick();
      if (obs_ag) begin
        if (first_gnt < 0) first_gnt = cyc;
        nreads++;
        if (nreads < 6) aux_op(1, 0, 4'hF, 32'(32'h200 + nreads * 4), 32'h0);
        else aux_op(0, 0, 4'h0, 32'h0, 32'h0);
      end
      cyc++;
    end
    chk("starve_all_reads_done", 72'(nreads), 72'(6));
`ifdef DMEM_ARB_STARVE_GUARD_EN
    chk("starve_first_gnt", 72'(first_gnt), 72'(16));
`else
    chk("starve_first_gnt", 72'(first_gnt), 72'(40));
`endif
    core_op(0, 0, 4'h0, 32'h0, 32'h0);
    aux_op(0, 0, 4'h0, 32'h0, 32'h0);
    tick();

    // reset in the cycle after an aux read grant
    aux_op(1, 0, 4'hF, 32'h0000_0020, 32'h0);
    tick();
    aux_op(0, 0, 4'h0, 32'h0, 32'h0);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("rst_aux_rvalid", 72'(bus.aux_rvalid), 72'(1'b0));
    chk("rst_aux_rdata", 72'(bus.aux_rdata), 72'(32'h0));
    tick();

    // aux byte write into a known word
    core_op(0, 1, 4'hF, 32'h0000_0030, 32'h1234_5678);
    tick();
    core_op(0, 0, 4'h0, 32'h0, 32'h0);
    aux_op(1, 1, 4'b0010, 32'h0000_0030, 32'h0000_AB00);
    #1;
    chk("byte_m_en", 72'(bus.m_en), 72'(4'b0010));
    tick();
    aux_op(0, 0, 4'h0, 32'h0, 32'h0);
    core_op(1, 0, 4'hF, 32'h0000_0030, 32'h0);
    tick();
    core_op(0, 0, 4'h0, 32'h0, 32'h0);
    chk("byte_readback", 72'(bus.core_dout), 72'(32'h1234_AB78));
    tick();

    // random traffic; held requesters keep their request stable
    for (int c = 0; c < 400; c++) begin
      creq_prev = bus.core_rea | bus.core_wea;
      if (!(creq_prev && !last_cg)) begin
        case ($urandom_range(0, 2))
          0:       core_op(0, 0, 4'h0, 32'h0, 32'h0);
          1:       core_op(1, 0, 4'hF, $urandom(), 32'h0);
          default: core_op(0, 1, 4'($urandom()), $urandom(), $urandom());
        endcase
      end
      if (!bus.aux_req || last_ag) begin
        aux_op($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 4'($urandom()),
               $urandom(), $urandom());
      end
      Rst = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
